line_word_packer: RTL and testbench

Word-to-line packer: the write-side counterpart of the pipelined line-to-word selector in the DT engine datapath. It accepts one WORD_WIDTH word per beat with a word index, places it into a DATA_WIDTH assembly line, and emits the completed line with a valid-word mask over a valid/ready interface. It sits upstream of line-wide memories and FIFOs so that results produced word by word can be stored as full lines.

---
 rtl/line_pack_pkg.sv | 15 +
 rtl/line_out_stage.sv | 56 +++++
 rtl/line_word_packer.sv | 81 ++++++++
 tb/tb_line_word_packer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pack_pkg.sv
// line_pack_pkg: shared state encoding and mask popcount for the word-to-line packer
package line_pack_pkg;

   typedef enum logic {FILL, HOLD} state_t;

   localparam int unsigned MAX_WORDS = 256;

   // Counts set bits among the low n entries of a mask that is zero-extended to MAX_WORDS.
   function automatic int unsigned popcount(input logic [MAX_WORDS-1:0] v, input int unsigned n);
      popcount = 0;
      for (int unsigned i = 0; i < MAX_WORDS; i++)
         if (i < n) popcount += 32'(v[i]);
   endfunction

endpackage

// File: rtl/line_out_stage.sv
// line_out_stage: output holding register for a finished line with load/drain handshake
module line_out_stage
   import line_pack_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int NUM_WORDS  = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] ld_line,
   input  logic [NUM_WORDS-1:0]  ld_mask,
   input  logic                  out_ready,
   output logic                  free,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_line,
   output logic [NUM_WORDS-1:0]  out_mask,
   output logic [CNT_WIDTH-1:0]  out_count
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] line_q, line_d;
   logic [NUM_WORDS-1:0]  mask_q, mask_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   assign free      = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_line  = line_q;
   assign out_mask  = mask_q;
   assign out_count = count_q;

   // A load replaces the held line; otherwise the line holds until drained.
   always_comb begin
      valid_d = load || (valid_q && !out_ready);
      line_d  = load ? ld_line : line_q;
      mask_d  = load ? ld_mask : mask_q;
      count_d = load ? CNT_WIDTH'(popcount(MAX_WORDS'(ld_mask), NUM_WORDS)) : count_q;
   end

   // Output register with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         line_q  <= '0;
         mask_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         line_q  <= line_d;
         mask_q  <= mask_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/line_word_packer.sv
// line_word_packer: assembles indexed words into a line and emits it with a valid-word mask
module line_word_packer
   import line_pack_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] in_word,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_line,
   output logic [(1<<ADDR_WIDTH)-1:0] out_mask,
   output logic [ADDR_WIDTH:0]   out_count
);

   localparam int NUM_WORDS = 1 << ADDR_WIDTH;

   state_t                               state_q, state_d;
   logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] asm_q, asm_d, merged;
   logic [NUM_WORDS-1:0]                 mask_q, mask_d, wr_en, wr_mask;
   logic                                 accept, close, free, load;

   // Ready comes only from registered state, gated low while reset is asserted.
   assign in_ready = rst_n && state_q == FILL;

   // Slot decode, merge of the incoming word, close detection and next state.
   always_comb begin
      wr_en  = '0;
      merged = asm_q;
      accept = in_valid && in_ready;
      for (int k = 0; k < NUM_WORDS; k++) begin
         wr_en[k]  = accept && in_addr == ADDR_WIDTH'(k);
         merged[k] = wr_en[k] ? in_word : asm_q[k];
      end
      wr_mask = mask_q | wr_en;
      close   = accept && (in_last || &wr_mask);
      load    = state_q == FILL ? close && free : free;
      state_d = load ? FILL : close ? HOLD : state_q;
      asm_d   = load ? '0 : merged;
      mask_d  = load ? '0 : wr_mask;
   end

   // Assembly buffer, mask and FSM state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
         asm_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         asm_q   <= asm_d;
         mask_q  <= mask_d;
      end
   end

   line_out_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (NUM_WORDS),
      .CNT_WIDTH  (ADDR_WIDTH + 1)
   ) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .ld_line   (merged),
      .ld_mask   (wr_mask),
      .out_ready (out_ready),
      .free      (free),
      .out_valid (out_valid),
      .out_line  (out_line),
      .out_mask  (out_mask),
      .out_count (out_count)
   );

endmodule

// File: tb/tb_line_word_packer.sv
// tb_line_word_packer: scoreboard bench with a slot/mask reference model
module tb_line_word_packer;

   localparam int DW = 512;
   localparam int WW = 32;
   localparam int AW = 4;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WW-1:0] in_word = '0;
   logic [AW-1:0] in_addr = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_line;
   logic [NW-1:0] out_mask;
   logic [AW:0]   out_count;

   int checks = 0;
   int errors = 0;
   bit rand_rdy = 1'b0;

   typedef struct {
      logic [DW-1:0] line;
      logic [NW-1:0] mask;
      int            count;
   } exp_t;

   exp_t          q[$];
   exp_t          mon_e;
   logic [WW-1:0] m_line[NW];
   logic [NW-1:0] m_mask;

   line_word_packer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_addr   (in_addr),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_line  (out_line),
      .out_mask  (out_mask),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < NW; k++) m_line[k] = '0;
      m_mask = '0;
   endtask

   // A line is a set of slots; it closes on in_last or once every slot has been written.
   task automatic model_accept(input logic [AW-1:0] a, input logic [WW-1:0] w, input logic l);
      exp_t e;
      m_line[a] = w;
      m_mask[a] = 1'b1;
      if (l || m_mask == {NW{1'b1}}) begin
         e.line = '0;
         for (int k = 0; k < NW; k++) e.line[k*WW +: WW] = m_line[k];
         e.mask  = m_mask;
         e.count = $countones(m_mask);
         q.push_back(e);
         model_clear();
      end
   endtask

   // Called just after a rising edge; returns just after the edge that accepted the word.
   task automatic send(input logic [AW-1:0] a, input logic [WW-1:0] w, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_addr  = a;
      in_word  = w;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready got 0 want 1");
      end else model_accept(a, w, l);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_queue", DW'(q.size()), '0);
      check("drain_valid", DW'(out_valid), '0);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every line handed downstream must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_line mask %0h count %0d want no line", out_mask, out_count);
         end else begin
            mon_e = q.pop_front();
            check("line", out_line, mon_e.line);
            check("mask", DW'(out_mask), DW'(mon_e.mask));
            check("count", DW'(out_count), DW'(mon_e.count));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) out_ready = $urandom_range(0, 9) < 7;
      end
   end

   initial begin
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", DW'(in_ready), '0);
      check("rst_out_valid", DW'(out_valid), '0);
      check("rst_out_line", out_line, '0);
      check("rst_out_mask", DW'(out_mask), '0);
      check("rst_out_count", DW'(out_count), '0);
      rst_n = 1'b1;
      idle();
      check("post_rst_in_ready", DW'(in_ready), DW'(1));
      check("post_rst_out_valid", DW'(out_valid), '0);

      out_ready = 1'b1;
      for (int a = 0; a < NW; a++) send(AW'(a), WW'(32'h100 + a), 1'b0);
      check("full_valid", DW'(out_valid), DW'(1));
      check("full_count", DW'(out_count), DW'(16));
      drain();

      send(4'd3, 32'h33, 1'b0);
      send(4'd7, 32'h77, 1'b0);
      check("sparse_not_yet", DW'(out_valid), '0);
      send(4'd12, 32'hCC, 1'b1);
      check("sparse_latency", DW'(out_valid), DW'(1));
      check("sparse_mask", DW'(out_mask), DW'(16'h1088));
      drain();

      send(4'd5, 32'hAAAA, 1'b0);
      send(4'd5, 32'hBBBB, 1'b1);
      check("ovw_mask", DW'(out_mask), DW'(16'h0020));
      check("ovw_slot5", DW'(out_line[5*WW +: WW]), DW'(32'hBBBB));
      drain();

      out_ready = 1'b0;
      send(4'd0, 32'd1, 1'b1);
      send(4'd1, 32'd2, 1'b1);
      check("bp_in_ready_low", DW'(in_ready), '0);
      repeat (3) idle();
      check("bp_hold_valid", DW'(out_valid), DW'(1));
      check("bp_hold_line", out_line, DW'(1));
      check("bp_hold_mask", DW'(out_mask), DW'(1));
      check("bp_still_stalled", DW'(in_ready), '0);
      out_ready = 1'b1;
      idle();
      out_ready = 1'b0;
      check("bp_line2_valid", DW'(out_valid), DW'(1));
      check("bp_line2_mask", DW'(out_mask), DW'(2));
      check("bp_line2_line", out_line, DW'(64'h2_0000_0000));
      check("bp_in_ready_back", DW'(in_ready), DW'(1));
      drain();

      for (int i = 0; i < 8; i++) begin
         send(AW'(i), WW'(32'h500 + i), 1'b1);
         check("b2b_valid", DW'(out_valid), DW'(1));
         check("b2b_count", DW'(out_count), DW'(1));
      end
      drain();

      for (int a = 0; a < 7; a++) send(AW'(a), WW'(32'h600 + a), 1'b0);
      check("mid_no_emit", DW'(out_valid), '0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", DW'(in_ready), '0);
      model_clear();
      q.delete();
      idle();
      rst_n = 1'b1;
      check("mid_rst_out_valid", DW'(out_valid), '0);
      send(4'd9, 32'h999, 1'b1);
      check("mid_post_mask", DW'(out_mask), DW'(16'h0200));
      check("mid_post_count", DW'(out_count), DW'(1));
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         send(AW'($urandom_range(0, NW - 1)), $urandom, $urandom_range(0, 5) == 0);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      send(4'd15, 32'hF00D, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
